// File: rtl/ahb_pkg.sv
// Shared AHB encodings, arbiter state type and burst-length helpers
// used by the bus arbiter and its round-robin picker.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [1:0] {
        PARK  = 2'd0,
        OWN   = 2'd1,
        BURST = 2'd2,
        LOCK  = 2'd3
    } arb_state_e;

    localparam int BEATS_W = 4;

    // Total beats of a burst type; 0 marks an undefined-length INCR burst.
    function automatic logic [4:0] burst_beats(hburst_e b);
        logic [4:0] n;
        case (b)
            SINGLE:         n = 5'd1;
            WRAP4, INCR4:   n = 5'd4;
            WRAP8, INCR8:   n = 5'd8;
            WRAP16, INCR16: n = 5'd16;
            default:        n = 5'd0;
        endcase
        return n;
    endfunction

    // Beats still to come after the NONSEQ of a burst has been accepted.
    function automatic logic [BEATS_W-1:0] burst_reload(hburst_e b);
        logic [4:0] n;
        n = burst_beats(b);
        return (n > 5'd1) ? BEATS_W'(n - 5'd1) : '0;
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin priority encoder: the first requester found
// scanning last+1, last+2, ... modulo N wins; 'last' itself is scanned last.
module ahb_rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] winner,
    output logic         any
);

    localparam logic [W:0] N_EXT = (W+1)'(N);

    logic [W-1:0] cand [N];
    logic [N-1:0] rot_req;

    // cand[gi] is the master index holding scan position gi.
    genvar gi;
    for (gi = 0; gi < N; gi++) begin : g_cand
        logic [W:0] sum;
        assign sum         = {1'b0, last} + (W+1)'(gi + 1);
        assign cand[gi]    = (sum >= N_EXT) ? W'(sum - N_EXT) : W'(sum);
        assign rot_req[gi] = req[cand[gi]];
    end

    always_comb begin
        winner = last;
        any    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                winner = cand[i];
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin, burst- and lock-aware AHB bus arbiter driving one-hot hgrant
// plus registered hmaster/hmastlock ownership for the address/data muxes.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                           hclk,
    input  logic                           hreset,
    input  logic [NUM_MASTERS-1:0]         hbusreq,
    input  logic [NUM_MASTERS-1:0]         hlock,
    input  logic [1:0]                     htrans,
    input  logic [2:0]                     hburst,
    input  logic                           hready,
    output logic [NUM_MASTERS-1:0]         hgrant,
    output logic [$clog2(NUM_MASTERS)-1:0] hmaster,
    output logic                           hmastlock
);

    localparam int                     MW        = $clog2(NUM_MASTERS);
    localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    arb_state_e                state_q, state_d;
    logic [MW-1:0]             gidx_q, gidx_d;
    logic [NUM_MASTERS-1:0]    grant_q, grant_d;
    logic [MW-1:0]             last_q, last_d;
    logic [MW-1:0]             hmaster_q, hmaster_d;
    logic                      hmastlock_q, hmastlock_d;
    logic [BEATS_W-1:0]        beats_q, beats_d;

    logic [MW-1:0]             pick_idx;
    logic                      pick_any;
    logic                      lock_cur;

    assign lock_cur = hlock[gidx_q];

    ahb_rr_picker #(
        .N (NUM_MASTERS),
        .W (MW)
    ) u_picker (
        .req    (hbusreq),
        .last   (last_q),
        .winner (pick_idx),
        .any    (pick_any)
    );

    // Beat counter follows the transfer being accepted on this edge, so the
    // arbitration decision below sees the burst as it will stand afterwards.
    always_comb begin
        beats_d = beats_q;
        if (hready) begin
            case (htrans_e'(htrans))
                NONSEQ:  beats_d = burst_reload(hburst_e'(hburst));
                SEQ:     beats_d = (beats_q == '0) ? '0 : beats_q - BEATS_W'(1);
                BUSY:    beats_d = beats_q;
                default: beats_d = '0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        gidx_d      = gidx_q;
        last_d      = last_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        if (hready) begin
            hmaster_d   = gidx_q;
            hmastlock_d = lock_cur;
            if (lock_cur) begin
                state_d = LOCK;
            end else if (state_q == LOCK) begin
                // Hold one more accepted transfer so the last locked data phase stays owned.
                state_d = (beats_d > BEATS_W'(1)) ? BURST : OWN;
            end else if (beats_d > BEATS_W'(1)) begin
                state_d = BURST;
            end else if (pick_any) begin
                gidx_d  = pick_idx;
                last_d  = pick_idx;
                state_d = OWN;
            end else begin
                gidx_d  = DEF_IDX;
                state_d = PARK;
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_grant
        assign grant_d[gi] = (gidx_d == MW'(gi));
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= PARK;
            gidx_q      <= DEF_IDX;
            grant_q     <= DEF_GRANT;
            last_q      <= DEF_IDX;
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
            beats_q     <= '0;
        end else begin
            state_q     <= state_d;
            gidx_q      <= gidx_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
            beats_q     <= beats_d;
        end
    end

    assign hgrant    = grant_q;
    assign hmaster   = hmaster_q;
    assign hmastlock = hmastlock_q;

endmodule
